pwm_mux_sel_sequencer: RTL and testbench

//  Drives sel_0 of the 8-input PWM-count mux, stepping it through a programmable window of inputs
//  [first..last], synchronised to carrier events (counter zero / period match).

---
 rtl/pwm_mux_sel_sequencer_pkg.sv | 34 +++
 rtl/pwm_mux_sel_sequencer_shadow_reg.sv | 70 +++++++
 rtl/pwm_mux_sel_sequencer.sv | 141 ++++++++++++++
 tb/tb_pwm_mux_sel_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_mux_sel_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pwm_mux_sel_sequencer_pkg
//   Shared types and constants for the PWM mux select sequencer:
//   sequencer state encoding, mux geometry, advance-source encodings and a
//   helper that turns carrier strobes into a single advance qualifier.
// ----------------------------------------------------------------------------
package pwm_mux_sel_sequencer_pkg;

   localparam int PWM_MUX_N     = 8;
   localparam int PWM_MUX_SEL_W = 3;

   // adv_mode encodings; the unused code 2'd3 behaves like ADV_ZERO
   localparam logic [1:0] ADV_ZERO   = 2'd0;
   localparam logic [1:0] ADV_PERIOD = 2'd1;
   localparam logic [1:0] ADV_EITHER = 2'd2;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_ARMED = 2'd1,
      SEQ_RUN   = 2'd2
   } pwm_seq_state_t;

   // Both strobes in the same cycle under ADV_EITHER still count as one advance.
   function automatic logic adv_event(input logic [1:0] mode,
                                      input logic       ez,
                                      input logic       ep);
      case (mode)
         ADV_PERIOD: return ep;
         ADV_EITHER: return ez | ep;
         default:    return ez;
      endcase
   endfunction

endpackage

// File: rtl/pwm_mux_sel_sequencer_shadow_reg.sv
// ----------------------------------------------------------------------------
// pwm_seq_shadow_reg
//   Pending/active configuration registers for the mux select sequencer.
//   A request captures cfg_* into the pending copy; the sequencer decides
//   when the pending copy may become active (apply), and an ack pulse marks it.
// Ports
//   clk, rstn               clock, async active-low reset
//   cfg_upd_req             capture cfg_first/last/dwell into pending
//   cfg_first/last/dwell    requested window and dwell
//   apply                   copy pending -> active this edge (only asserted while pend=1)
//   pend                    pending copy holds an unapplied update
//   pend_first              first index of the pending copy (wrap/arm target on apply)
//   act_first/last/dwell    active configuration used by the sequencer
//   cfg_upd_ack             1-cycle pulse after an apply
// ----------------------------------------------------------------------------
module pwm_seq_shadow_reg
   import pwm_mux_sel_sequencer_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     cfg_upd_req,
   input  logic [PWM_MUX_SEL_W-1:0] cfg_first,
   input  logic [PWM_MUX_SEL_W-1:0] cfg_last,
   input  logic [DWELL_W-1:0]       cfg_dwell,
   input  logic                     apply,
   output logic                     pend,
   output logic [PWM_MUX_SEL_W-1:0] pend_first,
   output logic [PWM_MUX_SEL_W-1:0] act_first,
   output logic [PWM_MUX_SEL_W-1:0] act_last,
   output logic [DWELL_W-1:0]       act_dwell,
   output logic                     cfg_upd_ack
);

   logic [PWM_MUX_SEL_W-1:0] pend_last;
   logic [DWELL_W-1:0]       pend_dwell;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend        <= 1'b0;
         pend_first  <= '0;
         pend_last   <= '0;
         pend_dwell  <= '0;
         act_first   <= '0;
         act_last    <= '0;
         act_dwell   <= '0;
         cfg_upd_ack <= 1'b0;
      end else begin
         cfg_upd_ack <= apply;
         // NOTE: non-blocking assignments make a request that coincides with an
         // apply copy the OLD pending values into active, while the new request
         // lands in pending for the next apply.
         if (apply) begin
            act_first <= pend_first;
            act_last  <= pend_last;
            act_dwell <= pend_dwell;
         end
         if (cfg_upd_req) begin
            pend_first <= cfg_first;
            pend_last  <= cfg_last;
            pend_dwell <= cfg_dwell;
            pend       <= 1'b1;
         end else if (apply) begin
            pend       <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pwm_mux_sel_sequencer.sv
// ----------------------------------------------------------------------------
// pwm_mux_sel_sequencer
//   Steps sel_0 of the 8-input PWM-count mux through the window [first..last]
//   (wrapping through 7->0 when first>last), advancing once every dwell+1
//   qualifying carrier events. Config changes apply only at sequence wrap
//   while running, or immediately when idle/armed.
// Ports
//   clk, rstn            clock, async active-low reset
//   en                   1 = run, 0 = return to IDLE
//   adv_mode             0=evt_zero 1=evt_period 2=either 3=evt_zero
//   evt_zero/evt_period  1-cycle carrier strobes
//   cfg_first/last/dwell requested window / events-per-step minus one
//   cfg_upd_req          capture cfg_* into pending
//   cfg_upd_ack          pending copied to active
//   sel_0                registered mux select
//   sel_valid            1 while in RUN
//   step_pulse           sel_0 advanced
//   wrap_pulse           sel_0 went last -> first
// ----------------------------------------------------------------------------
module pwm_mux_sel_sequencer
   import pwm_mux_sel_sequencer_pkg::*;
#(
   parameter int                       DWELL_W = 8,
   parameter logic [PWM_MUX_SEL_W-1:0] SEL_RST = '0
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     en,
   input  logic [1:0]               adv_mode,
   input  logic                     evt_zero,
   input  logic                     evt_period,
   input  logic [PWM_MUX_SEL_W-1:0] cfg_first,
   input  logic [PWM_MUX_SEL_W-1:0] cfg_last,
   input  logic [DWELL_W-1:0]       cfg_dwell,
   input  logic                     cfg_upd_req,
   output logic                     cfg_upd_ack,
   output logic [PWM_MUX_SEL_W-1:0] sel_0,
   output logic                     sel_valid,
   output logic                     step_pulse,
   output logic                     wrap_pulse
);

   pwm_seq_state_t           state_q, state_d;
   logic [PWM_MUX_SEL_W-1:0] sel_d, sel_inc, target_first;
   logic [DWELL_W-1:0]       dwell_cnt, dwell_d;
   logic                     step_d, wrap_d, wrap_step;
   logic                     adv, apply, pend;
   logic [PWM_MUX_SEL_W-1:0] pend_first, act_first, act_last;
   logic [DWELL_W-1:0]       act_dwell;

   pwm_seq_shadow_reg #(.DWELL_W(DWELL_W)) u_shadow (
      .clk         (clk),
      .rstn        (rstn),
      .cfg_upd_req (cfg_upd_req),
      .cfg_first   (cfg_first),
      .cfg_last    (cfg_last),
      .cfg_dwell   (cfg_dwell),
      .apply       (apply),
      .pend        (pend),
      .pend_first  (pend_first),
      .act_first   (act_first),
      .act_last    (act_last),
      .act_dwell   (act_dwell),
      .cfg_upd_ack (cfg_upd_ack)
   );

   assign adv       = adv_event(adv_mode, evt_zero, evt_period);
   assign sel_inc   = PWM_MUX_SEL_W'((int'(sel_0) + 1) % PWM_MUX_N);
   // Whenever first is loaded (arming or wrap) a pending update is applied on
   // the same edge, so the target is the pending first if one exists.
   assign target_first = pend ? pend_first : act_first;
   // Outside RUN a pending update applies right away; in RUN only on wrap.
   assign apply     = pend && ((state_q != SEQ_RUN) || wrap_step);
   assign sel_valid = (state_q == SEQ_RUN);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_d   = state_q;
      sel_d     = sel_0;
      dwell_d   = dwell_cnt;
      step_d    = 1'b0;
      wrap_d    = 1'b0;
      wrap_step = 1'b0;
      if (!en) begin
         state_d = SEQ_IDLE;
         sel_d   = SEL_RST;
         dwell_d = '0;
      end else begin
         case (state_q)
            SEQ_IDLE: state_d = SEQ_ARMED;
            SEQ_ARMED: begin
               if (adv) begin
                  state_d = SEQ_RUN;
                  sel_d   = target_first;
                  dwell_d = '0;
               end
            end
            SEQ_RUN: begin
               if (adv) begin
                  if (dwell_cnt == act_dwell) begin
                     dwell_d = '0;
                     step_d  = 1'b1;
                     if (sel_0 == act_last) begin
                        wrap_step = 1'b1;
                        wrap_d    = 1'b1;
                        sel_d     = target_first;
                     end else begin
                        sel_d     = sel_inc;
                     end
                  end else begin
                     dwell_d = dwell_cnt + DWELL_W'(1);
                  end
               end
            end
            default: begin
               state_d = SEQ_IDLE;
               sel_d   = SEL_RST;
               dwell_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= SEQ_IDLE;
         sel_0      <= SEL_RST;
         dwell_cnt  <= '0;
         step_pulse <= 1'b0;
         wrap_pulse <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_0      <= sel_d;
         dwell_cnt  <= dwell_d;
         step_pulse <= step_d;
         wrap_pulse <= wrap_d;
      end
   end

endmodule

// File: tb/tb_pwm_mux_sel_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pwm_mux_sel_sequencer
//   Directed scenarios followed by randomized traffic. A window/position
//   reference model predicts every observable output change; the expected
//   records are queued and a monitor pops and compares them against the DUT.
// ----------------------------------------------------------------------------
module tb_pwm_mux_sel_sequencer;

   localparam int         DWELL_W = 8;
   localparam logic [2:0] SEL_RST = 3'd0;

   logic               clk;
   logic               rstn;
   logic               en;
   logic [1:0]         adv_mode;
   logic               evt_zero, evt_period;
   logic [2:0]         cfg_first, cfg_last;
   logic [DWELL_W-1:0] cfg_dwell;
   logic               cfg_upd_req, cfg_upd_ack;
   logic [2:0]         sel_0;
   logic               sel_valid, step_pulse, wrap_pulse;

   pwm_mux_sel_sequencer #(.DWELL_W(DWELL_W), .SEL_RST(SEL_RST)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .en          (en),
      .adv_mode    (adv_mode),
      .evt_zero    (evt_zero),
      .evt_period  (evt_period),
      .cfg_first   (cfg_first),
      .cfg_last    (cfg_last),
      .cfg_dwell   (cfg_dwell),
      .cfg_upd_req (cfg_upd_req),
      .cfg_upd_ack (cfg_upd_ack),
      .sel_0       (sel_0),
      .sel_valid   (sel_valid),
      .step_pulse  (step_pulse),
      .wrap_pulse  (wrap_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // record = {sel_0[2:0], sel_valid, step_pulse, wrap_pulse, cfg_upd_ack}
   logic [6:0] sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- stimulus variables ----------------
   logic               s_rstn, s_en, s_ez, s_ep, s_req;
   logic [1:0]         s_mode;
   logic [2:0]         s_f, s_l;
   logic [DWELL_W-1:0] s_d;

   // ---------------- reference model ----------------
   // phase: 0 idle, 1 armed, 2 run. Output index = first + position in window.
   int                 m_ph, m_pos, m_cnt;
   logic [2:0]         m_af, m_al, m_pf, m_pl;
   logic [DWELL_W-1:0] m_ad, m_pd;
   logic               m_pend, m_step, m_wrap, m_ack;
   logic [6:0]         m_prev;

   task automatic model_step();
      int         cur, len;
      logic       adv, do_apply;
      logic [2:0] esel;
      logic [6:0] rec;
      m_step = 1'b0; m_wrap = 1'b0; m_ack = 1'b0;
      if (!s_rstn) begin
         m_ph = 0; m_pos = 0; m_cnt = 0;
         m_af = '0; m_al = '0; m_ad = '0; m_pend = 1'b0;
      end else begin
         adv      = (s_mode == 2'd1) ? s_ep : (s_mode == 2'd2) ? (s_ez | s_ep) : s_ez;
         cur      = m_ph;
         do_apply = 1'b0;
         len      = int'(3'(m_al - m_af)) + 1;
         if (!s_en) begin
            m_ph = 0; m_pos = 0; m_cnt = 0;
            do_apply = m_pend && (cur != 2);
         end else if (cur == 0) begin
            m_ph = 1;
            do_apply = m_pend;
         end else if (cur == 1) begin
            do_apply = m_pend;
            if (adv) begin m_ph = 2; m_pos = 0; m_cnt = 0; end
         end else if (adv) begin
            if (m_cnt == int'(m_ad)) begin
               m_cnt  = 0;
               m_step = 1'b1;
               if (m_pos == len - 1) begin
                  m_wrap   = 1'b1;
                  m_pos    = 0;
                  do_apply = m_pend;
               end else begin
                  m_pos++;
               end
            end else begin
               m_cnt++;
            end
         end
         if (do_apply) begin
            m_af = m_pf; m_al = m_pl; m_ad = m_pd; m_pend = 1'b0; m_ack = 1'b1;
         end
         if (s_req) begin
            m_pf = s_f; m_pl = s_l; m_pd = s_d; m_pend = 1'b1;
         end
      end
      esel = (m_ph == 2) ? 3'(m_af + 3'(m_pos)) : SEL_RST;
      rec  = {esel, (m_ph == 2), m_step, m_wrap, m_ack};
      if (rec != m_prev || rec[2:0] != 3'b000) sb.push_back(rec);
      m_prev = rec;
   endtask

   // One clock of stimulus: drive at negedge, predict the following posedge.
   task automatic cycle();
      @(negedge clk);
      rstn        = s_rstn;
      en          = s_en;
      adv_mode    = s_mode;
      evt_zero    = s_ez;
      evt_period  = s_ep;
      cfg_upd_req = s_req;
      cfg_first   = s_f;
      cfg_last    = s_l;
      cfg_dwell   = s_d;
      model_step();
      s_req = 1'b0; s_ez = 1'b0; s_ep = 1'b0;
   endtask

   task automatic setcfg(input logic [2:0] f, input logic [2:0] l, input logic [DWELL_W-1:0] d);
      s_req = 1'b1; s_f = f; s_l = l; s_d = d;
      cycle();
      cycle();
   endtask

   task automatic reqcfg(input logic [2:0] f, input logic [2:0] l, input logic [DWELL_W-1:0] d);
      s_req = 1'b1; s_f = f; s_l = l; s_d = d;
      cycle();
   endtask

   task automatic evz(input int n);
      for (int i = 0; i < n; i++) begin s_ez = 1'b1; cycle(); cycle(); end
   endtask

   task automatic evp(input int n);
      for (int i = 0; i < n; i++) begin s_ep = 1'b1; cycle(); cycle(); end
   endtask

   task automatic evb(input int n);
      for (int i = 0; i < n; i++) begin s_ez = 1'b1; s_ep = 1'b1; cycle(); cycle(); end
   endtask

   task automatic restart(input logic [2:0] f, input logic [2:0] l,
                          input logic [DWELL_W-1:0] d, input logic [1:0] mode);
      s_en = 1'b0; cycle();
      setcfg(f, l, d);
      s_mode = mode; s_en = 1'b1; cycle();
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [6:0] prev, cur;
      prev = {SEL_RST, 4'b0000};
      forever begin
         @(posedge clk);
         #1;
         cur = {sel_0, sel_valid, step_pulse, wrap_pulse, cfg_upd_ack};
         if (cur !== prev || cur[2:0] !== 3'b000) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL sb_unexpected actual=%0h expected=no_change @%0t", cur, $time);
            end else begin
               check("sb_rec", cur, sb.pop_front());
            end
         end
         prev = cur;
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      s_rstn = 1'b0; s_en = 1'b0; s_mode = 2'd0; s_ez = 1'b0; s_ep = 1'b0;
      s_req = 1'b0; s_f = '0; s_l = '0; s_d = '0;
      rstn = 1'b0; en = 1'b0; adv_mode = 2'd0; evt_zero = 1'b0; evt_period = 1'b0;
      cfg_upd_req = 1'b0; cfg_first = '0; cfg_last = '0; cfg_dwell = '0;
      m_ph = 0; m_pos = 0; m_cnt = 0; m_af = '0; m_al = '0; m_ad = '0;
      m_pf = '0; m_pl = '0; m_pd = '0; m_pend = 1'b0;
      m_prev = {SEL_RST, 4'b0000};

      repeat (3) cycle();
      s_rstn = 1'b1;
      cycle();
      check("rst_sel", sel_0, SEL_RST);
      check("rst_valid", sel_valid, 0);
      check("rst_pulses", {step_pulse, wrap_pulse, cfg_upd_ack}, 0);

      // window 2..5, one event per step
      restart(3'd2, 3'd5, 8'd0, 2'd0);
      evz(6);
      check("win25_end_sel", sel_0, 3);

      // dwell 2, either-mode, coincident strobes count once
      restart(3'd1, 3'd3, 8'd2, 2'd2);
      evb(7);
      evz(2);
      evp(3);
      check("dwell_valid", sel_valid, 1);

      // window crossing 7->0, period events
      restart(3'd6, 3'd1, 8'd0, 2'd1);
      evp(6);
      evz(2);
      // single-entry window
      restart(3'd4, 3'd4, 8'd0, 2'd3);
      evz(4);
      check("single_sel", sel_0, 4);

      // shadow update while running, and last-wins double request
      restart(3'd2, 3'd5, 8'd0, 2'd0);
      evz(2);
      reqcfg(3'd0, 3'd1, 8'd0);
      cycle();
      evz(3);
      check("shadow_sel", sel_0, 0);
      reqcfg(3'd4, 3'd5, 8'd0);
      cycle();
      reqcfg(3'd6, 3'd7, 8'd0);
      cycle();
      evz(4);

      // en drop and re-arm
      restart(3'd2, 3'd5, 8'd0, 2'd0);
      evz(3);
      s_en = 1'b0; cycle(); cycle();
      check("en_off_sel", sel_0, SEL_RST);
      check("en_off_valid", sel_valid, 0);
      s_en = 1'b1; cycle();
      evz(1);
      check("rearm_sel", sel_0, 2);

      // async reset mid-run with a pending update that must be discarded
      restart(3'd3, 3'd6, 8'd1, 2'd0);
      evz(3);
      reqcfg(3'd0, 3'd7, 8'd1);
      evz(1);
      s_rstn = 1'b0; s_en = 1'b0; cycle(); cycle();
      s_rstn = 1'b1; cycle(); cycle(); cycle();
      check("midrst_sel", sel_0, SEL_RST);
      check("midrst_valid", sel_valid, 0);
      s_en = 1'b1; cycle();
      evz(3);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         s_en   = ($urandom_range(0, 39) != 0);
         s_mode = 2'($urandom_range(0, 3));
         s_ez   = ($urandom_range(0, 2) == 0);
         s_ep   = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 29) == 0) begin
            s_req = 1'b1;
            s_f   = 3'($urandom_range(0, 7));
            s_l   = 3'($urandom_range(0, 7));
            s_d   = DWELL_W'($urandom_range(0, 3));
         end
         s_rstn = ($urandom_range(0, 599) != 0);
         cycle();
      end

      s_rstn = 1'b1; s_en = 1'b0;
      repeat (4) cycle();
      @(posedge clk);
      #2;
      check("sb_drain", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
